// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU field widths, rounding modes, operand classes.
// Imported by the multiplier and the sequential divider.
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int QW    = 26;

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;

  localparam logic [EXP_W-1:0] EXP_INF  = '1;
  localparam logic [MAN_W-1:0] MAN_QNAN = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0] MAN_MAXF = '1;

  typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;

  typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} div_state_e;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             invalid;
    logic             overflow;
    logic             underflow;
    logic             inexact;
    logic             zero;
  } fp_res_t;

  function automatic fp_class_e fp_class(
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] m
  );
    fp_class_e c;
    c = NORM;
    if (e == '0)
      c = ZERO;
    else if (e == EXP_INF)
      c = (m == '0) ? INF : (m[MAN_W-1] ? QNAN : SNAN);
    return c;
  endfunction
endpackage

// File: rtl/fp_div_core.sv
// fp_div_core: radix-2 restoring divider datapath for fp_div_seq.
// One quotient bit per enabled cycle; sticky is the final remainder.
module fp_div_core
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [MAN_W+1:0] dividend,
  input  logic [MAN_W:0]   divisor,
  output logic [QW-1:0]    quotient,
  output logic             sticky,
  output logic             done
);
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_INIT = CW'(QW - 1);

  logic [MAN_W+1:0] rem;
  logic [MAN_W:0]   dsr;
  logic [CW-1:0]    cnt;
  logic [MAN_W+2:0] diff;
  logic             borrow;

  assign diff   = {1'b0, rem} - {2'b00, dsr};
  assign borrow = diff[MAN_W+2];
  assign sticky = |rem;
  assign done   = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      quotient <= '0;
    end else if (load) begin
      rem      <= dividend;
      dsr      <= divisor;
      cnt      <= CNT_INIT;
      quotient <= '0;
    end else if (en) begin
      rem      <= borrow ? {rem[MAN_W:0], 1'b0}
                         : {diff[MAN_W:0], 1'b0};
      quotient <= {quotient[QW-2:0], ~borrow};
      if (!done)
        cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative IEEE-754 single divider, X / Y, DAZ inputs.
// Define FP_DIV_DIVZERO_FLAG_EN to add the divzero_flag output.
module fp_div_seq
  import fpu_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             Sx,
  input  logic             Sy,
  input  logic [EXP_W-1:0] Ex,
  input  logic [EXP_W-1:0] Ey,
  input  logic [MAN_W-1:0] Mx,
  input  logic [MAN_W-1:0] My,
  input  logic [1:0]       R_mode,
  output logic             busy,
  output logic             valid,
  output logic             Sz,
  output logic [EXP_W-1:0] Ez,
  output logic [MAN_W-1:0] Mz,
  output logic             invalid_flag,
  output logic             overflow_flag,
  output logic             underflow_flag,
  output logic             inexact_flag,
  output logic             zero_flag
`ifdef FP_DIV_DIVZERO_FLAG_EN
  ,
  output logic             divzero_flag
`endif
);
  localparam logic [EXP_W+1:0] BIAS_W = (EXP_W+2)'(BIAS);

  div_state_e       state;
  logic             sx_q;
  logic             sy_q;
  logic [EXP_W-1:0] ex_q;
  logic [EXP_W-1:0] ey_q;
  logic [MAN_W-1:0] mx_q;
  logic [MAN_W-1:0] my_q;
  logic [1:0]       rm_q;
  logic [EXP_W+1:0] exp_q;
  fp_res_t          res;

  logic             sgn;
  fp_class_e        cx;
  fp_class_e        cy;
  logic [MAN_W:0]   sig_x;
  logic [MAN_W:0]   sig_y;
  logic             shift;
  logic [MAN_W+1:0] dividend;
  logic [EXP_W+1:0] exp_un;

  assign sgn      = sx_q ^ sy_q;
  assign cx       = fp_class(ex_q, mx_q);
  assign cy       = fp_class(ey_q, my_q);
  assign sig_x    = {1'b1, mx_q};
  assign sig_y    = {1'b1, my_q};
  assign shift    = sig_x < sig_y;
  assign dividend = shift ? {sig_x, 1'b0} : {1'b0, sig_x};
  assign exp_un   = {2'b00, ex_q} - {2'b00, ey_q} + BIAS_W
                  - {{(EXP_W+1){1'b0}}, shift};

  logic    x_nan;
  logic    y_nan;
  logic    inv_op;
  logic    sp_any;
  logic    sp_divzero;
  fp_res_t sp_res;

  assign x_nan  = (cx == QNAN) || (cx == SNAN);
  assign y_nan  = (cy == QNAN) || (cy == SNAN);
  assign inv_op = (cx == SNAN) || (cy == SNAN)
               || (cx == ZERO && cy == ZERO)
               || (cx == INF && cy == INF);

  always_comb begin
    sp_res     = '0;
    sp_res.sgn = sgn;
    sp_any     = 1'b1;
    sp_divzero = 1'b0;
    priority case (1'b1)
      x_nan || y_nan || inv_op: begin
        sp_res.sgn     = 1'b0;
        sp_res.exp     = EXP_INF;
        sp_res.man     = MAN_QNAN;
        sp_res.invalid = inv_op;
      end
      cx == INF:  sp_res.exp  = EXP_INF;
      cy == INF:  sp_res.zero = 1'b1;
      cx == ZERO: sp_res.zero = 1'b1;
      cy == ZERO: begin
        sp_res.exp = EXP_INF;
        sp_divzero = 1'b1;
      end
      default: sp_any = 1'b0;
    endcase
  end

  logic [QW-1:0] quotient;
  logic          sticky;
  logic          core_done;

  fp_div_core u_core (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (state == UNPACK && !sp_any),
    .en       (state == DIV),
    .dividend (dividend),
    .divisor  (sig_y),
    .quotient (quotient),
    .sticky   (sticky),
    .done     (core_done)
  );

  // quotient = 1.fff (24 bits) then guard and round
  logic [MAN_W:0]   sig_q;
  logic             g_bit;
  logic             r_bit;
  logic             inx;
  logic             up;
  logic [MAN_W+1:0] sig_rnd;
  logic [EXP_W+1:0] exp_rnd;
  logic             ovf;
  logic             unf;
  logic             unused_hidden;
  fp_res_t          rd_res;

  assign sig_q = quotient[QW-1:2];
  assign g_bit = quotient[1];
  assign r_bit = quotient[0];
  assign inx   = g_bit | r_bit | sticky;

  always_comb begin
    up = 1'b0;
    unique case (rm_q)
      RNE: up = g_bit & (r_bit | sticky | sig_q[0]);
      RTZ: up = 1'b0;
      RUP: up = ~sgn & inx;
      RDN: up = sgn & inx;
      default: up = 1'b0;
    endcase
  end

  assign sig_rnd = {1'b0, sig_q} + {{(MAN_W+1){1'b0}}, up};
  assign exp_rnd = exp_q + {{(EXP_W+1){1'b0}}, sig_rnd[MAN_W+1]};
  assign ovf     = ~exp_rnd[EXP_W+1]
                 & (exp_rnd[EXP_W:0] >= {1'b0, EXP_INF});
  assign unf     = exp_rnd[EXP_W+1] | (exp_rnd == '0);
  assign unused_hidden = sig_rnd[MAN_W];

  always_comb begin
    rd_res     = '0;
    rd_res.sgn = sgn;
    if (ovf) begin
      rd_res.overflow = 1'b1;
      rd_res.inexact  = 1'b1;
      if (rm_q == RTZ || (rm_q == RUP && sgn)
          || (rm_q == RDN && !sgn)) begin
        rd_res.exp = EXP_MAXF;
        rd_res.man = MAN_MAXF;
      end else begin
        rd_res.exp = EXP_INF;
      end
    end else if (unf) begin
      rd_res.underflow = 1'b1;
      rd_res.inexact   = 1'b1;
      rd_res.zero      = 1'b1;
    end else begin
      rd_res.exp     = exp_rnd[EXP_W-1:0];
      rd_res.man     = sig_rnd[MAN_W-1:0];
      rd_res.inexact = inx;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      busy           <= 1'b0;
      valid          <= 1'b0;
      sx_q           <= 1'b0;
      sy_q           <= 1'b0;
      ex_q           <= '0;
      ey_q           <= '0;
      mx_q           <= '0;
      my_q           <= '0;
      rm_q           <= RNE;
      exp_q          <= '0;
      res            <= '0;
      Sz             <= 1'b0;
      Ez             <= '0;
      Mz             <= '0;
      invalid_flag   <= 1'b0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
      inexact_flag   <= 1'b0;
      zero_flag      <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sx_q  <= Sx;
            sy_q  <= Sy;
            ex_q  <= Ex;
            ey_q  <= Ey;
            mx_q  <= Mx;
            my_q  <= My;
            rm_q  <= R_mode;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          exp_q <= exp_un;
          if (sp_any) begin
            res   <= sp_res;
            state <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          if (core_done)
            state <= ROUND;
        end
        ROUND: begin
          res   <= rd_res;
          state <= DONE;
        end
        DONE: begin
          valid          <= 1'b1;
          busy           <= 1'b0;
          Sz             <= res.sgn;
          Ez             <= res.exp;
          Mz             <= res.man;
          invalid_flag   <= res.invalid;
          overflow_flag  <= res.overflow;
          underflow_flag <= res.underflow;
          inexact_flag   <= res.inexact;
          zero_flag      <= res.zero;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_DIV_DIVZERO_FLAG_EN
  logic dz_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dz_q         <= 1'b0;
      divzero_flag <= 1'b0;
    end else begin
      if (state == UNPACK)
        dz_q <= sp_divzero;
      if (state == DONE)
        divzero_flag <= dz_q;
    end
  end
`else
  logic unused_divzero;
  assign unused_divzero = sp_divzero;
`endif
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed vectors for fp_div_seq, checked against an
// arithmetic division model and hand-computed literal results.
`timescale 1ns/1ps
module tb_fp_div_seq;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        Sx = 1'b0;
  logic        Sy = 1'b0;
  logic [7:0]  Ex = '0;
  logic [7:0]  Ey = '0;
  logic [22:0] Mx = '0;
  logic [22:0] My = '0;
  logic [1:0]  R_mode = '0;
  logic        busy;
  logic        valid;
  logic        Sz;
  logic [7:0]  Ez;
  logic [22:0] Mz;
  logic        invalid_flag;
  logic        overflow_flag;
  logic        underflow_flag;
  logic        inexact_flag;
  logic        zero_flag;
`ifdef FP_DIV_DIVZERO_FLAG_EN
  logic        divzero_flag;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fp_div_seq dut (
    .CLK            (CLK),
    .RST            (RST),
    .start          (start),
    .Sx             (Sx),
    .Sy             (Sy),
    .Ex             (Ex),
    .Ey             (Ey),
    .Mx             (Mx),
    .My             (My),
    .R_mode         (R_mode),
    .busy           (busy),
    .valid          (valid),
    .Sz             (Sz),
    .Ez             (Ez),
    .Mz             (Mz),
    .invalid_flag   (invalid_flag),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag),
    .inexact_flag   (inexact_flag),
    .zero_flag      (zero_flag)
`ifdef FP_DIV_DIVZERO_FLAG_EN
    ,
    .divzero_flag   (divzero_flag)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [31:0] z_dut;
  logic [4:0]  fl_dut;
  assign z_dut  = {Sz, Ez, Mz};
  assign fl_dut = {invalid_flag, overflow_flag, underflow_flag,
                   inexact_flag, zero_flag};

  typedef struct {
    logic [31:0] z;
    logic [4:0]  fl;
    logic        dz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t pend[$];
  exp_t cur;

  // flags: {invalid, overflow, underflow, inexact, zero}
  function automatic exp_t model(input logic [31:0] x,
                                 input logic [31:0] y,
                                 input logic [1:0]  rm);
    exp_t m;
    logic s;
    int ex, ey, e;
    logic xz, yz, xi, yi, xn, yn, xs, ys;
    longint unsigned a, b, num, q, rem, sig;
    logic g, r, st, up;
    m.z = '0; m.fl = '0; m.dz = 1'b0; m.lat = 2; m.t0 = 0;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xs = xn && !x[22];
    ys = yn && !y[22];
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      m.z     = 32'h7FC00000;
      m.fl[4] = xs || ys || (xz && yz) || (xi && yi);
    end else if (xi) begin
      m.z = {s, 8'hFF, 23'h0};
    end else if (yi || xz) begin
      m.z     = {s, 31'h0};
      m.fl[0] = 1'b1;
    end else if (yz) begin
      m.z  = {s, 8'hFF, 23'h0};
      m.dz = 1'b1;
    end else begin
      m.lat = 29;
      a = 64'h800000 | 64'(x[22:0]);
      b = 64'h800000 | 64'(y[22:0]);
      e = ex - ey + 127;
      if (a < b) begin
        a = a * 2;
        e = e - 1;
      end
      num = a << 25;
      q   = num / b;
      rem = num % b;
      sig = q >> 2;
      g   = q[1];
      r   = q[0];
      st  = (rem != 0);
      case (rm)
        2'd0:    up = g && (r || st || sig[0]);
        2'd1:    up = 1'b0;
        2'd2:    up = !s && (g || r || st);
        default: up = s && (g || r || st);
      endcase
      sig = sig + 64'(up);
      if (sig == (64'd1 << 24)) begin
        sig = 64'd1 << 23;
        e   = e + 1;
      end
      if (e >= 255) begin
        m.fl = 5'b01010;
        if (rm == 2'd1 || (rm == 2'd2 && s) || (rm == 2'd3 && !s))
          m.z = {s, 8'hFE, 23'h7FFFFF};
        else
          m.z = {s, 8'hFF, 23'h0};
      end else if (e <= 0) begin
        m.z  = {s, 31'h0};
        m.fl = 5'b00111;
      end else begin
        m.z     = {s, 8'(e), sig[22:0]};
        m.fl[1] = g || r || st;
      end
    end
    return m;
  endfunction

  always @(negedge CLK) begin
    if (RST) begin
      if (pend.size() == 0) begin
        if (valid) begin
          total++; bad++;
          $display("FAIL spurious_valid at cyc=%0d got z=%h", cyc, z_dut);
        end
      end else if (cyc >= pend[0].t0) begin
        cur = pend[0];
        total++;
        if (busy !== (cyc < cur.t0 + cur.lat)) begin
          bad++;
          $display("FAIL busy cyc=%0d got %b need %b", cyc, busy,
                   (cyc < cur.t0 + cur.lat));
        end
        if (valid) begin
          total++;
          if (cyc - cur.t0 != cur.lat) begin
            bad++;
            $display("FAIL latency got %0d need %0d", cyc - cur.t0, cur.lat);
          end
          total++;
          if (z_dut !== cur.z) begin
            bad++;
            $display("FAIL result got %h need %h", z_dut, cur.z);
          end
          total++;
          if (fl_dut !== cur.fl) begin
            bad++;
            $display("FAIL flags got %b need %b", fl_dut, cur.fl);
          end
`ifdef FP_DIV_DIVZERO_FLAG_EN
          total++;
          if (divzero_flag !== cur.dz) begin
            bad++;
            $display("FAIL divzero got %b need %b", divzero_flag, cur.dz);
          end
`endif
          void'(pend.pop_front());
        end else if (cyc >= cur.t0 + cur.lat) begin
          total++; bad++;
          $display("FAIL missing_valid cyc=%0d need z=%h", cyc, cur.z);
          void'(pend.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input logic [1:0] rm);
    Sx = x[31]; Ex = x[30:23]; Mx = x[22:0];
    Sy = y[31]; Ey = y[30:23]; My = y[22:0];
    R_mode = rm;
  endtask

  task automatic launch(input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] rm);
    exp_t m;
    @(posedge CLK); #2;
    drive(x, y, rm);
    start = 1'b1;
    m = model(x, y, rm);
    m.t0 = cyc + 1;
    pend.push_back(m);
    @(posedge CLK); #2;
    start = 1'b0;
    drive($urandom, $urandom, 2'($urandom_range(3)));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pend.size() != 0 && n < 60) begin
      @(posedge CLK);
      n++;
    end
    if (pend.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout no result after %0d cycles", n);
      pend.delete();
    end
    @(posedge CLK); #2;
  endtask

  task automatic check_lit(input string name, input logic [31:0] z,
                           input logic [4:0] fl);
    total++;
    if (z_dut !== z) begin
      bad++;
      $display("FAIL %s z got %h need %h", name, z_dut, z);
    end
    total++;
    if (fl_dut !== fl) begin
      bad++;
      $display("FAIL %s flags got %b need %b", name, fl_dut, fl);
    end
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  rm;
    logic [31:0] z;
    logic [4:0]  fl;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV] = '{
    '{32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000},
    '{32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00010},
    '{32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00010},
    '{32'h3F800000, 32'h40400000, 2'd2, 32'h3EAAAAAB, 5'b00010},
    '{32'hBF800000, 32'h40400000, 2'd2, 32'hBEAAAAAA, 5'b00010},
    '{32'hBF800000, 32'h40400000, 2'd3, 32'hBEAAAAAB, 5'b00010},
    '{32'h00000000, 32'h00000000, 2'd0, 32'h7FC00000, 5'b10000},
    '{32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000, 5'b00000},
    '{32'h7F7FFFFF, 32'h3F000000, 2'd0, 32'h7F800000, 5'b01010},
    '{32'h7F7FFFFF, 32'h3F000000, 2'd1, 32'h7F7FFFFF, 5'b01010},
    '{32'hFF7FFFFF, 32'h3F000000, 2'd2, 32'hFF7FFFFF, 5'b01010},
    '{32'hFF7FFFFF, 32'h3F000000, 2'd3, 32'hFF800000, 5'b01010},
    '{32'h00800000, 32'h40000000, 2'd0, 32'h00000000, 5'b00111},
    '{32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b00000},
    '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b10000},
    '{32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 5'b00000},
    '{32'hC0000000, 32'h7F800000, 2'd0, 32'h80000000, 5'b00001},
    '{32'h7F800000, 32'h7F800000, 2'd0, 32'h7FC00000, 5'b10000},
    '{32'h00000001, 32'h3F800000, 2'd0, 32'h00000000, 5'b00001},
    '{32'h3FC00000, 32'h3F800000, 2'd0, 32'h3FC00000, 5'b00000},
    '{32'h3F800000, 32'hC0000000, 2'd0, 32'hBF000000, 5'b00000}
  };

  task automatic run_vec(input int i);
    exp_t m;
    string nm;
    nm = $sformatf("vec%0d", i);
    m = model(vecs[i].x, vecs[i].y, vecs[i].rm);
    total++;
    if (m.z !== vecs[i].z || m.fl !== vecs[i].fl) begin
      bad++;
      $display("FAIL %s model got %h/%b need %h/%b", nm, m.z, m.fl,
               vecs[i].z, vecs[i].fl);
    end
    launch(vecs[i].x, vecs[i].y, vecs[i].rm);
    wait_done();
    check_lit(nm, vecs[i].z, vecs[i].fl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    #12;
    total++;
    if ({busy, valid, z_dut, fl_dut} !== '0) begin
      bad++;
      $display("FAIL reset_state got busy=%b valid=%b z=%h fl=%b",
               busy, valid, z_dut, fl_dut);
    end
    @(posedge CLK); #2;
    RST = 1'b1;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < NV; i++)
      run_vec(i);

    // second start mid-operation must be ignored
    launch(32'h40C00000, 32'h40000000, 2'd0);
    repeat (9) @(posedge CLK);
    #2;
    drive(32'h3F800000, 32'h40400000, 2'd1);
    start = 1'b1;
    @(posedge CLK); #2;
    start = 1'b0;
    wait_done();
    check_lit("ignored_start", 32'h40400000, 5'b00000);

    // reset mid-operation aborts without a result
    launch(32'h3F800000, 32'h40400000, 2'd0);
    repeat (14) @(posedge CLK);
    #2;
    RST = 1'b0;
    pend.delete();
    #1;
    total++;
    if ({busy, valid, z_dut, fl_dut} !== '0) begin
      bad++;
      $display("FAIL abort_reset got busy=%b valid=%b z=%h fl=%b",
               busy, valid, z_dut, fl_dut);
    end
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    repeat (35) @(posedge CLK);
    run_vec(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Iterative IEEE-754 single-precision divider, X / Y. It is the inverse-operation companion to the FPU multiplier.
- Same unpacked operand and flag interface as the multiplier, plus a start/busy/valid handshake.
- Radix-2 restoring division, one quotient bit per cycle, then a single round/pack cycle.
- Sits beside the multiplier under the FPU top and shares the rounding-mode encoding.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width.
- BIAS, 127, exponent bias.
- QW, 26, quotient bits generated: 24 significand + guard + round. Sticky comes from the final remainder.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- Sx,Sy  in  1  operand signs (X dividend, Y divisor).
- Ex,Ey  in  EXP_W  biased exponents.
- Mx,My  in  MAN_W  stored fractions.
- R_mode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
- busy  out  1  high from the accept cycle until valid.
- valid  out  1  one-cycle result pulse.
- Sz,Ez,Mz  out  1/EXP_W/MAN_W  result.
- invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag  out  1 each  exception flags.

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset asserted mid-operation aborts to IDLE; no valid pulse is produced.
- Operands, start and R_mode are latched on the accept edge. Inputs may change afterwards without effect.
- start while busy=1 is ignored. Results and flags hold from valid until the next accepted start.
- FSM states: IDLE, UNPACK, DIV, ROUND, DONE.
- IDLE -> UNPACK on start.
  - UNPACK classifies the operands. Subnormal inputs are treated as zero (DAZ).
  - Special case -> DONE.
  - Otherwise -> DIV, with the iteration counter loaded to QW-1.
- DIV runs QW cycles.
  - Each cycle: rem = rem - divisor; quotient bit = no borrow; restore on borrow; rem shifted left 1.
  - Counter 0 -> ROUND.
- ROUND:
  - sticky = (rem != 0).
  - Round per R_mode on the L/G/R/sticky bits.
  - Mantissa carry-out -> significand 1.0, exponent +1.
  - Then range check -> DONE.
- DONE drives valid=1 for one cycle and clears busy -> IDLE.
- Latency from the start edge to the valid-high edge:
  - Normal operands: QW+3 = 29 cycles.
  - Special cases: 2 cycles.
- Normalisation: in UNPACK, if 1.Mx < 1.My, the dividend is shifted left 1 and the exponent decremented, so the quotient lies in [1,2). Exponent = Ex - Ey + BIAS (minus 1 if shifted), computed in a signed EXP_W+2 bit width.
- Sign: Sz = Sx ^ Sy for every result except NaN.
- Special cases, in priority order:
  - Any NaN, 0/0, or inf/inf -> qNaN (Sz=0, Ez=all ones, Mz=0x400000).
    - invalid_flag=1 for sNaN inputs, 0/0 and inf/inf.
    - invalid_flag=0 for quiet-NaN propagation.
  - inf/finite -> inf.
  - finite/inf -> zero.
  - 0/finite -> zero.
  - finite/0 -> inf.
- Overflow (rounded exponent >= 255): overflow_flag=1 and inexact_flag=1.
  - RNE -> inf.
  - RTZ -> max finite.
  - Toward +inf -> +inf if positive, else -max finite.
  - Toward -inf -> mirror of toward +inf.
- Underflow (exponent <= 0): flush to signed zero with underflow_flag, inexact_flag and zero_flag all set.
- inexact_flag = G|R|sticky for normal results.
- zero_flag = 1 whenever the result is zero.

Optional Feature:
- Macro: FP_DIV_DIVZERO_FLAG_EN.
- Defined: adds output port divzero_flag (1 bit, reset 0). It is set with valid for finite-nonzero/0 and held with the result.
- Undefined: the port is absent. finite/0 still returns signed inf with all other flags 0.

Decomposition:
- Shared package fpu_pkg:
  - Rounding-mode constants RNE/RTZ/RUP/RDN.
  - EXP_W, MAN_W, BIAS.
  - qNaN, inf and max-finite field constants.
  - Operand-class typedef: ZERO/NORM/INF/QNAN/SNAN.
- One natural sub-module: fp_div_core, holding the remainder/quotient registers and the counter. It takes load/en and provides quotient, sticky and done.
- Rounding and exception logic stays in fp_div_seq.

Test Plan:
- 6.0/2.0 (0x40C00000/0x40000000), RNE -> 0x40400000, all flags 0, valid exactly 29 cycles after start, busy high throughout.
- 1.0/3.0 (0x3F800000/0x40400000):
  - RNE -> 0x3EAAAAAB.
  - RTZ -> 0x3EAAAAAA.
  - inexact=1 in both modes.
- 0/0 -> 0x7FC00000 with invalid=1. 1.0/0 -> 0x7F800000 (divzero_flag=1 when the macro is defined). Both valid after 2 cycles.
- 0x7F7FFFFF/0.5:
  - RNE -> 0x7F800000.
  - RTZ -> 0x7F7FFFFF.
  - overflow=1 and inexact=1 in both modes.
- 0x00800000/2.0 -> 0x00000000 with underflow, inexact and zero flags all set.
- start pulsed again at cycle 10 is ignored. RST low at cycle 15 clears busy/outputs, no valid pulse, and a subsequent start completes normally.
